// File: rtl/br_resolve_unit.sv
// Back-end half of the gshare predictor: checkpoint queue, in-order branch
// resolution, PHT counter read-modify-write and GHR restore on mispredict.
module br_resolve_unit #(
  parameter int GHR_W = 14,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  output logic                     pred_ready,
  input  logic [GHR_W-1:0]         pred_ghr,
  input  logic [GHR_W-1:0]         pred_pc,
  input  logic                     pred_taken,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic                     res_taken,
  output logic                     pht_rd_en,
  output logic [GHR_W-1:0]         pht_rd_idx,
  input  logic [1:0]               pht_rd_data,
  output logic                     pht_wr_en,
  output logic [GHR_W-1:0]         pht_wr_idx,
  output logic [1:0]               pht_wr_data,
  output logic                     ghr_re_en,
  output logic [GHR_W-1:0]         ghr_re_data,
  output logic                     mispredict,
  output logic [CNT_W-1:0]         resolved_cnt,
  output logic [CNT_W-1:0]         mispred_cnt,
  output logic [1:0]               dbg_state,
  output logic [$clog2(DEPTH):0]   dbg_count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2} state_t;
  state_t state_q, state_d;

  logic [GHR_W-1:0] q_ghr [DEPTH];
  logic [GHR_W-1:0] q_pc  [DEPTH];
  logic             q_tk  [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;

  logic [GHR_W-1:0] w_ghr_q, w_pc_q;
  logic             w_ck_tk_q, w_res_tk_q;

  logic             rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic             re_en_q, re_en_d, mis_q, mis_d;
  logic [GHR_W-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d, re_data_q, re_data_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d, mis_cnt_q, mis_cnt_d;

  logic miss, flush, push, pop;

  // Both ports are valid/ready: a transfer happens on the cycle where valid and
  // ready are both high; ready depends only on registered state and reset.
  assign miss       = (w_ck_tk_q != w_res_tk_q);
  assign flush      = (state_q == S_WR) && miss;
  assign pred_ready = !reset && (count_q != FULL) && !flush;
  assign res_ready  = !reset && (state_q == S_IDLE) && (count_q != '0);
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && res_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pop) state_d = S_RD;
      S_RD:    state_d = S_WR;
      S_WR:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: next values of the registered strobes, indices and statistics
  always_comb begin
    rd_en_d   = pop;
    rd_idx_d  = pop ? (q_ghr[rd_ptr_q] ^ q_pc[rd_ptr_q]) : '0;
    wr_en_d   = (state_q == S_RD);
    wr_idx_d  = wr_en_d ? (w_ghr_q ^ w_pc_q) : '0;
    re_en_d   = (state_q == S_RD) && miss;
    mis_d     = re_en_d;
    re_data_d = re_en_d ? {w_ghr_q[GHR_W-2:0], w_res_tk_q} : '0;
    res_cnt_d = res_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (wr_en_d && (res_cnt_q != '1)) res_cnt_d = res_cnt_q + CNT_W'(1);
    if (re_en_d && (mis_cnt_q != '1)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_q   <= 1'b0;
      rd_idx_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      re_en_q   <= 1'b0;
      re_data_q <= '0;
      mis_q     <= 1'b0;
      res_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      rd_en_q   <= rd_en_d;
      rd_idx_q  <= rd_idx_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      re_en_q   <= re_en_d;
      re_data_q <= re_data_d;
      mis_q     <= mis_d;
      res_cnt_q <= res_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ghr_q    <= '0;
      w_pc_q     <= '0;
      w_ck_tk_q  <= 1'b0;
      w_res_tk_q <= 1'b0;
    end else if (pop) begin
      w_ghr_q    <= q_ghr[rd_ptr_q];
      w_pc_q     <= q_pc[rd_ptr_q];
      w_ck_tk_q  <= q_tk[rd_ptr_q];
      w_res_tk_q <= res_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_ghr[wr_ptr_q] <= pred_ghr;
      q_pc[wr_ptr_q]  <= pred_pc;
      q_tk[wr_ptr_q]  <= pred_taken;
    end
  end

  // A mispredict discards every younger checkpoint, including wrong-path pushes
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= rd_ptr_q;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // The counter update uses read data returned in the write cycle
  always_comb begin
    pht_wr_data = '0;
    if (wr_en_q) begin
      if (w_res_tk_q) pht_wr_data = (pht_rd_data == 2'd3) ? 2'd3 : pht_rd_data + 2'd1;
      else            pht_wr_data = (pht_rd_data == 2'd0) ? 2'd0 : pht_rd_data - 2'd1;
    end
  end

  assign pht_rd_en    = rd_en_q;
  assign pht_rd_idx   = rd_idx_q;
  assign pht_wr_en    = wr_en_q;
  assign pht_wr_idx   = wr_idx_q;
  assign ghr_re_en    = re_en_q;
  assign ghr_re_data  = re_data_q;
  assign mispredict   = mis_q;
  assign resolved_cnt = res_cnt_q;
  assign mispred_cnt  = mis_cnt_q;
  assign dbg_state    = state_q;
  assign dbg_count    = count_q;
endmodule

// File: tb/tb_br_resolve_unit.sv
// Scoreboard bench for br_resolve_unit: a checkpoint-list reference model
// predicts ready flags, queue occupancy and every PHT/GHR update.
module tb_br_resolve_unit;
  localparam int GW = 14;
  localparam int DEPTH = 8;
  localparam int CW = 16;
  localparam int EW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, pred_valid, pred_ready, pred_taken;
  logic [GW-1:0] pred_ghr, pred_pc;
  logic          res_valid, res_ready, res_taken;
  logic          pht_rd_en, pht_wr_en, ghr_re_en, mispredict;
  logic [GW-1:0] pht_rd_idx, pht_wr_idx, ghr_re_data;
  logic [1:0]    pht_rd_data, pht_wr_data, dbg_state;
  logic [CW-1:0] resolved_cnt, mispred_cnt;
  logic [3:0]    dbg_count;

  br_resolve_unit #(.GHR_W(GW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_ghr(pred_ghr),
    .pred_pc(pred_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .pht_rd_en(pht_rd_en), .pht_rd_idx(pht_rd_idx), .pht_rd_data(pht_rd_data),
    .pht_wr_en(pht_wr_en), .pht_wr_idx(pht_wr_idx), .pht_wr_data(pht_wr_data),
    .ghr_re_en(ghr_re_en), .ghr_re_data(ghr_re_data), .mispredict(mispredict),
    .resolved_cnt(resolved_cnt), .mispred_cnt(mispred_cnt),
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  typedef struct {
    logic [GW-1:0] ghr;
    logic [GW-1:0] pc;
    logic          tk;
  } ckpt_t;

  ckpt_t         model_q[$];
  logic [EW-1:0] exp_q[$];
  logic [GW-1:0] rd_exp_q[$];
  int            total = 0;
  int            bad = 0;
  int            phase = 0;
  bit            cur_miss = 1'b0;
  int            m_res = 0;
  int            m_mis = 0;
  logic [1:0]    rd_next = 2'd0;
  bit            mon_en = 1'b0;
  bit            tk_list[$];

  function automatic logic [1:0] sat_upd(input logic [1:0] c, input bit t);
    int v;
    v = t ? int'(c) + 1 : int'(c) - 1;
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model advances as if the edge had happened
  task automatic step(input bit pv, input logic [GW-1:0] g, input logic [GW-1:0] p,
                      input bit t, input bit rv, input bit rt, input bit rst);
    bit pr_exp, rr_exp, acc_res, miss;
    ckpt_t ck;
    logic [GW-1:0] re, idx;
    @(posedge clk);
    #1;
    reset = rst; pred_valid = pv; pred_ghr = g; pred_pc = p; pred_taken = t;
    res_valid = rv; res_taken = rt;
    rr_exp  = !rst && (phase == 0) && (model_q.size() != 0);
    pr_exp  = !rst && (model_q.size() < DEPTH) && !(phase == 2 && cur_miss);
    acc_res = rv && rr_exp;
    if (acc_res) pht_rd_data = rd_next;
    #1;
    chk("pred_ready", EW'(pred_ready), EW'(pr_exp));
    chk("res_ready", EW'(res_ready), EW'(rr_exp));
    if (!rst) chk("count", EW'(dbg_count), EW'(model_q.size()));
    if (rst) begin
      model_q.delete(); exp_q.delete();
      phase = 0; cur_miss = 1'b0; m_res = 0; m_mis = 0;
    end else begin
      if (phase == 2) begin
        if (cur_miss) model_q.delete();
        phase = 0;
      end else if (phase == 1) begin
        phase = 2;
      end
      if (acc_res) begin
        ck = model_q.pop_front();
        miss = (ck.tk != rt);
        idx = ck.ghr ^ ck.pc;
        re = miss ? GW'((int'(ck.ghr) * 2 + int'(rt)) % (1 << GW)) : '0;
        if (m_res < 65535) m_res++;
        if (miss && m_mis < 65535) m_mis++;
        rd_exp_q.push_back(idx);
        exp_q.push_back({idx, sat_upd(rd_next, rt), miss, miss, re, CW'(m_res), CW'(m_mis)});
        cur_miss = miss;
        phase = 1;
      end
      if (pv && pr_exp) model_q.push_back('{ghr: g, pc: p, tk: t});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [GW-1:0] g, input logic [GW-1:0] p, input bit t);
    step(1'b1, g, p, t, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input bit rt, input logic [1:0] rd);
    rd_next = rd;
    step(1'b0, '0, '0, 1'b0, 1'b1, rt, 1'b0);
    idle(2);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i > 0) begin
        chk("rst_pht", EW'({pht_rd_en, pht_rd_idx, pht_wr_en, pht_wr_idx, pht_wr_data}), '0);
        chk("rst_ghr", EW'({ghr_re_en, ghr_re_data, mispredict, resolved_cnt, mispred_cnt}), '0);
      end
    end
  endtask

  // Monitor: compares each PHT read and each write/restore against the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      if (pht_rd_en) begin
        if (rd_exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got rd_en=1 idx=%0h expected no read", pht_rd_idx);
        end else chk("rd_idx", EW'(pht_rd_idx), EW'(rd_exp_q.pop_front()));
      end
      if (pht_wr_en) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: got wr_en=1 idx=%0h expected no write", pht_wr_idx);
        end else
          chk("wr_update", {pht_wr_idx, pht_wr_data, mispredict, ghr_re_en,
                            (ghr_re_en ? ghr_re_data : GW'(0)), resolved_cnt, mispred_cnt},
              exp_q.pop_front());
      end else begin
        chk("idle_strobes", EW'({mispredict, ghr_re_en}), '0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pred_valid = 1'b0; pred_ghr = '0; pred_pc = '0; pred_taken = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0; pht_rd_data = 2'd0;
    do_reset(2);
    mon_en = 1'b1;
    idle(1);

    // correct prediction, then saturation at 3
    push(14'h0005, 14'h0003, 1'b1);
    resolve(1'b1, 2'd2);
    idle(1);
    push(14'h0005, 14'h0003, 1'b1);
    resolve(1'b1, 2'd3);

    // mispredict with flush of younger entries
    push(14'h1FFF, 14'h0000, 1'b1);
    push(14'(($urandom)), 14'($urandom), 1'b0);
    push(14'($urandom), 14'($urandom), 1'b1);
    resolve(1'b0, 2'd0);
    idle(2);

    // full queue, ninth push refused, resolve all in order across wrap
    tk_list.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      bit t;
      t = 1'($urandom_range(0, 1));
      if (i < DEPTH) tk_list.push_back(t);
      push(14'($urandom), 14'($urandom), t);
    end
    for (int i = 0; i < DEPTH; i++) resolve(tk_list[i], 2'($urandom_range(0, 3)));
    idle(1);

    // push during RD of a mispredict is flushed
    push(14'h0123, 14'h0456, 1'b1);
    rd_next = 2'd1;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 14'h0aaa, 14'h0555, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // push during WR of a correct resolution is accepted
    push(14'h0010, 14'h0020, 1'b0);
    push(14'h0030, 14'h0040, 1'b1);
    rd_next = 2'd2;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 14'h0050, 14'h0060, 1'b0, 1'b0, 1'b0, 1'b0);
    resolve(1'b1, 2'd1);
    resolve(1'b0, 2'd1);
    idle(1);

    // reset during RD abandons the operation
    push(14'h0777, 14'h0111, 1'b0);
    push(14'h0222, 14'h0333, 1'b1);
    rd_next = 2'd3;
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rd_next = 2'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), 14'($urandom), 14'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), 1'b0);
    end
    idle(4);
    chk("exp_drained", EW'(exp_q.size()), '0);
    chk("rd_drained", EW'(rd_exp_q.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
